// File: rtl/timing_control.sv
// Sequence counter and control-signal decoder for the basic computer.
// Steps each instruction through T0..T6 and issues one command per register per cycle.
//
// state | meaning
// T0    | fetch: PC -> AR
// T1    | fetch: M[AR] -> IR, PC+1
// T2    | decode: IR[11:0] -> AR, latch I and D
// T3    | register-ref execute, or indirect address fetch
// T4    | memory-ref execute step 1
// T5    | memory-ref execute step 2
// T6    | ISZ write-back and skip
// T_BAD | unreachable; ends with no strobes
module timing_control (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        run,
   input  logic [15:0] ir,
   input  logic        dr_zero,
   output logic        ar_load,
   output logic        ar_inc,
   output logic        pc_load,
   output logic        pc_inc,
   output logic        dr_load,
   output logic        dr_inc,
   output logic        ac_load,
   output logic        ac_inc,
   output logic        ac_clr,
   output logic        ir_load,
   output logic        mem_read,
   output logic        mem_write,
   output logic [2:0]  bus_sel,
   output logic [1:0]  alu_op,
   output logic [2:0]  sc,
   output logic        halted
);

   typedef enum logic [2:0] {
      T0    = 3'd0,
      T1    = 3'd1,
      T2    = 3'd2,
      T3    = 3'd3,
      T4    = 3'd4,
      T5    = 3'd5,
      T6    = 3'd6,
      T_BAD = 3'd7
   } t_state_e;

   localparam logic [2:0] BUS_NONE = 3'd0;
   localparam logic [2:0] BUS_AR   = 3'd1;
   localparam logic [2:0] BUS_PC   = 3'd2;
   localparam logic [2:0] BUS_DR   = 3'd3;
   localparam logic [2:0] BUS_AC   = 3'd4;
   localparam logic [2:0] BUS_IR   = 3'd5;
   localparam logic [2:0] BUS_MEM  = 3'd7;

   // Command vector bit order, msb first:
   // ar_load ar_inc pc_load pc_inc dr_load dr_inc ac_load ac_inc ac_clr ir_load mem_read mem_write
   localparam logic [11:0] C_AR_LD  = 12'h800;
   localparam logic [11:0] C_AR_INC = 12'h400;
   localparam logic [11:0] C_PC_LD  = 12'h200;
   localparam logic [11:0] C_PC_INC = 12'h100;
   localparam logic [11:0] C_DR_LD  = 12'h080;
   localparam logic [11:0] C_DR_INC = 12'h040;
   localparam logic [11:0] C_AC_LD  = 12'h020;
   localparam logic [11:0] C_AC_INC = 12'h010;
   localparam logic [11:0] C_AC_CLR = 12'h008;
   localparam logic [11:0] C_IR_LD  = 12'h004;
   localparam logic [11:0] C_RD     = 12'h002;
   localparam logic [11:0] C_WR     = 12'h001;

   t_state_e    sc_q, sc_d;
   logic        i_q, halted_q, hlt_set, fin;
   logic [2:0]  d_q, bus_c;
   logic [1:0]  alu_c;
   logic [11:0] cmd_c, cmd;
   logic        active;
   logic        unused_ir;

   assign unused_ir = ^{ir[10:6], ir[4:1]};
   assign active    = rst_n & run & ~halted_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sc_q     <= T0;
         i_q      <= 1'b0;
         d_q      <= 3'd0;
         halted_q <= 1'b0;
      end else if (run && !halted_q) begin
         sc_q <= sc_d;
         if (sc_q == T2) begin
            i_q <= ir[15];
            d_q <= ir[14:12];
         end
         if (hlt_set) halted_q <= 1'b1;
      end
   end

   always_comb begin
      cmd_c   = 12'h000;
      bus_c   = BUS_NONE;
      alu_c   = 2'b00;
      fin     = 1'b0;
      hlt_set = 1'b0;
      unique case (sc_q)
         T0: begin cmd_c = C_AR_LD; bus_c = BUS_PC; end
         T1: begin cmd_c = C_RD | C_IR_LD | C_PC_INC; bus_c = BUS_MEM; end
         T2: begin cmd_c = C_AR_LD; bus_c = BUS_IR; end
         T3: begin
            if (d_q == 3'd7) begin
               fin = 1'b1;
               if (!i_q) begin
                  if (ir[11])     cmd_c = C_AC_CLR;
                  else if (ir[5]) cmd_c = C_AC_INC;
                  hlt_set = ir[0];
               end
            end else if (i_q) begin
               cmd_c = C_RD | C_AR_LD;
               bus_c = BUS_MEM;
            end
         end
         T4: begin
            unique case (d_q)
               3'd0, 3'd1, 3'd2, 3'd6: begin cmd_c = C_RD | C_DR_LD; bus_c = BUS_MEM; end
               3'd3: begin cmd_c = C_WR; bus_c = BUS_AC; fin = 1'b1; end
               3'd4: begin cmd_c = C_PC_LD; bus_c = BUS_AR; fin = 1'b1; end
               3'd5: begin cmd_c = C_WR | C_AR_INC; bus_c = BUS_PC; end
               default: fin = 1'b1;
            endcase
         end
         T5: begin
            unique case (d_q)
               3'd0: begin cmd_c = C_AC_LD; alu_c = 2'b01; fin = 1'b1; end
               3'd1: begin cmd_c = C_AC_LD; alu_c = 2'b10; fin = 1'b1; end
               3'd2: begin cmd_c = C_AC_LD; alu_c = 2'b00; fin = 1'b1; end
               3'd5: begin cmd_c = C_PC_LD; bus_c = BUS_AR; fin = 1'b1; end
               3'd6: cmd_c = C_DR_INC;
               default: fin = 1'b1;
            endcase
         end
         T6: begin
            fin = 1'b1;
            if (d_q == 3'd6) begin
               cmd_c = C_WR | (dr_zero ? C_PC_INC : 12'h000);
               bus_c = BUS_DR;
            end
         end
         default: fin = 1'b1;
      endcase
      sc_d = fin ? T0 : t_state_e'(sc_q + 3'd1);
   end

   assign cmd = active ? cmd_c : 12'h000;
   assign {ar_load, ar_inc, pc_load, pc_inc, dr_load, dr_inc,
           ac_load, ac_inc, ac_clr, ir_load, mem_read, mem_write} = cmd;
   assign bus_sel = active ? bus_c : BUS_NONE;
   assign alu_op  = active ? alu_c : 2'b00;
   assign sc      = rst_n ? sc_q : 3'd0;
   assign halted  = rst_n & halted_q;

endmodule

// File: tb/tb_timing_control.sv
// Scoreboard bench for timing_control: stimulus queues per-cycle expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_timing_control;

   logic        clk = 1'b0;
   logic        rst_n, run, dr_zero;
   logic [15:0] ir;
   logic        ar_load, ar_inc, pc_load, pc_inc, dr_load, dr_inc;
   logic        ac_load, ac_inc, ac_clr, ir_load, mem_read, mem_write;
   logic [2:0]  bus_sel, sc;
   logic [1:0]  alu_op;
   logic        halted;

   timing_control dut (
      .clk(clk), .rst_n(rst_n), .run(run), .ir(ir), .dr_zero(dr_zero),
      .ar_load(ar_load), .ar_inc(ar_inc), .pc_load(pc_load), .pc_inc(pc_inc),
      .dr_load(dr_load), .dr_inc(dr_inc), .ac_load(ac_load), .ac_inc(ac_inc),
      .ac_clr(ac_clr), .ir_load(ir_load), .mem_read(mem_read), .mem_write(mem_write),
      .bus_sel(bus_sel), .alu_op(alu_op), .sc(sc), .halted(halted)
   );

   always #5 clk = ~clk;

   localparam logic [11:0] AR_LD  = 12'h800;
   localparam logic [11:0] AR_INC = 12'h400;
   localparam logic [11:0] PC_LD  = 12'h200;
   localparam logic [11:0] PC_INC = 12'h100;
   localparam logic [11:0] DR_LD  = 12'h080;
   localparam logic [11:0] DR_INC = 12'h040;
   localparam logic [11:0] AC_LD  = 12'h020;
   localparam logic [11:0] AC_INC = 12'h010;
   localparam logic [11:0] AC_CLR = 12'h008;
   localparam logic [11:0] IR_LD  = 12'h004;
   localparam logic [11:0] RD     = 12'h002;
   localparam logic [11:0] WR     = 12'h001;
   localparam logic [11:0] NONE   = 12'h000;

   typedef struct {
      string       name;
      logic [20:0] v;
   } exp_t;

   exp_t q[$];
   int   tests  = 0;
   int   failed = 0;

   logic [20:0] act;
   assign act = {ar_load, ar_inc, pc_load, pc_inc, dr_load, dr_inc, ac_load, ac_inc,
                 ac_clr, ir_load, mem_read, mem_write, bus_sel, alu_op, sc, halted};

   always @(negedge clk) begin
      if (q.size() > 0) begin
         exp_t e;
         logic conflict;
         e = q.pop_front();
         tests++;
         if (act !== e.v) begin
            failed++;
            $display("FAIL %s: got %06h expected %06h (strobes/bus/alu/sc/halted)",
                     e.name, act, e.v);
         end
         conflict = (ar_load & ar_inc) | (pc_load & pc_inc) | (dr_load & dr_inc) |
                    (ac_load & ac_inc) | (ac_load & ac_clr) | (ac_inc & ac_clr) |
                    (mem_read & mem_write);
         tests++;
         if (conflict !== 1'b0) begin
            failed++;
            $display("FAIL %s_conflict: got %b expected 0", e.name, conflict);
         end
      end
   end

   task automatic step(input string nm, input logic [11:0] s, input logic [2:0] b,
                       input logic [1:0] a, input logic [2:0] scv, input logic h);
      exp_t e;
      e.name = nm;
      e.v    = {s, b, a, scv, h};
      q.push_back(e);
      @(posedge clk);
      #1;
   endtask

   task automatic fetch(input string nm, input logic [15:0] instr);
      ir = instr;
      step({nm, "_t0"}, AR_LD, 3'd2, 2'b00, 3'd0, 1'b0);
      step({nm, "_t1"}, RD | IR_LD | PC_INC, 3'd7, 2'b00, 3'd1, 1'b0);
      step({nm, "_t2"}, AR_LD, 3'd5, 2'b00, 3'd2, 1'b0);
   endtask

   task automatic mem_read_dr(input string nm, input logic ind, input logic [2:0] alu);
      if (ind) step({nm, "_t3"}, RD | AR_LD, 3'd7, 2'b00, 3'd3, 1'b0);
      else     step({nm, "_t3"}, NONE, 3'd0, 2'b00, 3'd3, 1'b0);
      step({nm, "_t4"}, RD | DR_LD, 3'd7, 2'b00, 3'd4, 1'b0);
      step({nm, "_t5"}, AC_LD, 3'd0, alu[1:0], 3'd5, 1'b0);
   endtask

   initial begin
      rst_n = 1'b0; run = 1'b1; ir = 16'h0000; dr_zero = 1'b0;
      @(posedge clk);
      #1;
      step("reset0", NONE, 3'd0, 2'b00, 3'd0, 1'b0);
      step("reset1", NONE, 3'd0, 2'b00, 3'd0, 1'b0);
      rst_n = 1'b1;

      fetch("add", 16'h1123);   mem_read_dr("add", 1'b0, 3'b010);
      fetch("lda_i", 16'hA050); mem_read_dr("lda_i", 1'b1, 3'b000);
      fetch("and", 16'h0000);   mem_read_dr("and", 1'b0, 3'b001);

      for (int k = 0; k < 2; k++) begin
         fetch("isz", 16'h6010);
         step("isz_t3", NONE, 3'd0, 2'b00, 3'd3, 1'b0);
         step("isz_t4", RD | DR_LD, 3'd7, 2'b00, 3'd4, 1'b0);
         step("isz_t5", DR_INC, 3'd0, 2'b00, 3'd5, 1'b0);
         dr_zero = (k == 0);
         if (k == 0) step("isz_t6_skip", WR | PC_INC, 3'd3, 2'b00, 3'd6, 1'b0);
         else        step("isz_t6_noskip", WR, 3'd3, 2'b00, 3'd6, 1'b0);
         dr_zero = 1'b0;
      end

      fetch("sta", 16'h3000);
      step("sta_t3", NONE, 3'd0, 2'b00, 3'd3, 1'b0);
      step("sta_t4", WR, 3'd4, 2'b00, 3'd4, 1'b0);

      fetch("cla", 16'h7800);
      step("cla_t3", AC_CLR, 3'd0, 2'b00, 3'd3, 1'b0);
      fetch("inc", 16'h7020);
      step("inc_t3", AC_INC, 3'd0, 2'b00, 3'd3, 1'b0);
      fetch("cla_inc", 16'h7820);
      step("cla_inc_t3", AC_CLR, 3'd0, 2'b00, 3'd3, 1'b0);
      fetch("io", 16'hF821);
      step("io_t3", NONE, 3'd0, 2'b00, 3'd3, 1'b0);

      // Freeze at T1 for three cycles, then resume.
      ir = 16'h4000;
      step("bun_t0", AR_LD, 3'd2, 2'b00, 3'd0, 1'b0);
      run = 1'b0;
      for (int k = 0; k < 3; k++) step("freeze", NONE, 3'd0, 2'b00, 3'd1, 1'b0);
      run = 1'b1;
      step("bun_t1", RD | IR_LD | PC_INC, 3'd7, 2'b00, 3'd1, 1'b0);
      step("bun_t2", AR_LD, 3'd5, 2'b00, 3'd2, 1'b0);
      step("bun_t3", NONE, 3'd0, 2'b00, 3'd3, 1'b0);
      step("bun_t4", PC_LD, 3'd1, 2'b00, 3'd4, 1'b0);

      // Reset during T4 of an ADD aborts it.
      fetch("abort", 16'h1123);
      step("abort_t3", NONE, 3'd0, 2'b00, 3'd3, 1'b0);
      rst_n = 1'b0;
      step("abort_rst", NONE, 3'd0, 2'b00, 3'd0, 1'b0);
      rst_n = 1'b1;

      fetch("bsa", 16'h5020);
      step("bsa_t3", NONE, 3'd0, 2'b00, 3'd3, 1'b0);
      step("bsa_t4", WR | AR_INC, 3'd2, 2'b00, 3'd4, 1'b0);
      step("bsa_t5", PC_LD, 3'd1, 2'b00, 3'd5, 1'b0);

      fetch("hlt", 16'h7001);
      step("hlt_t3", NONE, 3'd0, 2'b00, 3'd3, 1'b0);
      for (int k = 0; k < 10; k++) step("halted", NONE, 3'd0, 2'b00, 3'd0, 1'b1);
      rst_n = 1'b0;
      step("hlt_rst", NONE, 3'd0, 2'b00, 3'd0, 1'b0);
      rst_n = 1'b1;
      ir = 16'h0000;
      step("post_hlt_t0", AR_LD, 3'd2, 2'b00, 3'd0, 1'b0);

      for (int k = 0; k < 20 && q.size() > 0; k++) @(posedge clk);
      tests++;
      if (q.size() != 0) begin
         failed++;
         $display("FAIL drain: got %0d pending expected 0", q.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
